// File: rtl/sample_frame_loader.sv
// Double-buffered sample capture: writes fs-strobed samples into one of two RAM
// banks and hands completed frames to the heapsort stage in order.
module sample_frame_loader #(
    parameter int unsigned DATA_W = 16,
    parameter int unsigned ADDR_W = 10
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              fs,
    input  logic              en_rec_in,
    input  logic [DATA_W-1:0] data_in,
    input  logic              sort_done,
    output logic              ram_we,
    output logic [ADDR_W:0]   ram_addr,
    output logic [DATA_W-1:0] ram_wdata,
    output logic              frame_valid,
    output logic              frame_bank,
    output logic              overrun
);

    localparam logic [ADDR_W-1:0] LAST_IDX = '1;

    logic              fs_d;
    logic [ADDR_W-1:0] wr_ptr;
    logic              wr_bank;
    logic              rd_bank;
    logic [1:0]        full;

    logic              fs_edge_c;
    logic              release_c;
    logic              wr_full_c;
    logic              accept_c;
    logic              drop_c;
    logic              last_c;
    logic [1:0]        full_nxt_c;

    // A release is honoured only once frame_valid/frame_bank already show the
    // bank being released, so a stale frame_valid right after a release is ignored.
    always_comb begin
        fs_edge_c  = fs & ~fs_d;
        release_c  = sort_done & frame_valid & (frame_bank == rd_bank) & full[rd_bank];
        wr_full_c  = full[wr_bank] & ~(release_c & (rd_bank == wr_bank));
        accept_c   = fs_edge_c & en_rec_in & ~wr_full_c;
        drop_c     = fs_edge_c & en_rec_in & wr_full_c;
        last_c     = accept_c & (wr_ptr == LAST_IDX);
        full_nxt_c = full;
        if (release_c) begin
            full_nxt_c[rd_bank] = 1'b0;
        end
        if (last_c) begin
            full_nxt_c[wr_bank] = 1'b1;
        end
    end

    // Frame status outputs lag the bank flags by one cycle.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            fs_d        <= 1'b0;
            ram_we      <= 1'b0;
            ram_addr    <= '0;
            ram_wdata   <= '0;
            wr_ptr      <= '0;
            wr_bank     <= 1'b0;
            rd_bank     <= 1'b0;
            full        <= 2'b00;
            frame_valid <= 1'b0;
            frame_bank  <= 1'b0;
            overrun     <= 1'b0;
        end else begin
            fs_d        <= fs;
            ram_we      <= accept_c;
            full        <= full_nxt_c;
            frame_valid <= full[rd_bank];
            frame_bank  <= rd_bank;
            overrun     <= overrun | drop_c;
            if (accept_c) begin
                ram_addr  <= {wr_bank, wr_ptr};
                ram_wdata <= data_in;
                wr_ptr    <= wr_ptr + ADDR_W'(1);
            end
            if (last_c) begin
                wr_bank <= ~wr_bank;
            end
            if (release_c) begin
                rd_bank <= ~rd_bank;
            end
        end
    end

endmodule

// File: tb/tb_sample_frame_loader.sv
// Bench for sample_frame_loader: directed scenarios with literal expectations,
// then random traffic compared every cycle against a counting model.
`timescale 1ns/1ps
module tb_sample_frame_loader;

    localparam int unsigned DW = 16;
    localparam int unsigned AW = 2;
    localparam int unsigned AB = AW + 1;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          fs = 1'b0;
    logic          en_rec_in = 1'b0;
    logic [DW-1:0] data_in = '0;
    logic          sort_done = 1'b0;
    logic          ram_we;
    logic [AW:0]   ram_addr;
    logic [DW-1:0] ram_wdata;
    logic          frame_valid;
    logic          frame_bank;
    logic          overrun;

    sample_frame_loader #(.DATA_W(DW), .ADDR_W(AW)) dut (
        .clk(clk), .rst(rst), .fs(fs), .en_rec_in(en_rec_in), .data_in(data_in),
        .sort_done(sort_done), .ram_we(ram_we), .ram_addr(ram_addr),
        .ram_wdata(ram_wdata), .frame_valid(frame_valid), .frame_bank(frame_bank),
        .overrun(overrun)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad = 0;
    bit chk_on = 1'b0;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
        end
    endtask

    // Model: m_n samples accepted since reset, m_r frames released since reset.
    // Completed frames = m_n / 2^AW; the write address is simply m_n modulo 2^(AW+1).
    int            m_n, m_r, m_pend;
    bit            m_fs_d, m_edge, m_rel, m_wfull, m_acc;
    logic          e_we, e_fv, e_fb, e_ovr;
    logic [AW:0]   e_addr;
    logic [DW-1:0] e_wdata;

    task m_reset();
        m_n = 0; m_r = 0; m_fs_d = 1'b0;
        e_we = 1'b0; e_fv = 1'b0; e_fb = 1'b0; e_ovr = 1'b0;
        e_addr = '0; e_wdata = '0;
    endtask

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            m_reset();
        end else begin
            m_edge  = fs && !m_fs_d;
            m_fs_d  = fs;
            m_pend  = (m_n >> AW) - m_r;
            m_rel   = sort_done && e_fv && (e_fb == m_r[0]) && (m_pend > 0);
            m_wfull = ((m_pend - int'(m_rel)) == 2);
            m_acc   = m_edge && en_rec_in && !m_wfull;
            e_fv    = (m_pend > 0);
            e_fb    = m_r[0];
            e_we    = m_acc;
            if (m_acc) begin
                e_addr  = AB'(m_n);
                e_wdata = data_in;
                m_n++;
            end
            if (m_edge && en_rec_in && m_wfull) e_ovr = 1'b1;
            if (m_rel) m_r++;
        end
    end

    always @(negedge clk) begin
        if (chk_on) begin
            chk("cyc_ram_we", ram_we, e_we);
            chk("cyc_ram_addr", ram_addr, e_addr);
            chk("cyc_ram_wdata", ram_wdata, e_wdata);
            chk("cyc_frame_valid", frame_valid, e_fv);
            chk("cyc_frame_bank", frame_bank, e_fb);
            chk("cyc_overrun", overrun, e_ovr);
        end
    end

    task automatic do_reset();
        @(negedge clk);
        fs = 1'b0;
        sort_done = 1'b0;
        #2 rst = 1'b0;
        #1;
        chk("rst_ram_we", ram_we, 0);
        chk("rst_ram_addr", ram_addr, 0);
        chk("rst_ram_wdata", ram_wdata, 0);
        chk("rst_frame_valid", frame_valid, 0);
        chk("rst_frame_bank", frame_bank, 0);
        chk("rst_overrun", overrun, 0);
        repeat (2) @(negedge clk);
        #2 rst = 1'b1;
    endtask

    // One fs period of two clocks; returns at the falling edge just after the sampling edge.
    task automatic send(input logic [DW-1:0] d);
        @(negedge clk);
        fs = 1'b1;
        data_in = d;
        @(negedge clk);
        fs = 1'b0;
    endtask

    task automatic expect_wr(input int addr, input logic [DW-1:0] d);
        chk("wr_we", ram_we, 1);
        chk("wr_addr", ram_addr, addr);
        chk("wr_data", ram_wdata, d);
    endtask

    initial begin
        do_reset();
        chk_on = 1'b1;
        en_rec_in = 1'b1;

        for (int i = 0; i < 4; i++) begin
            send(DW'(i + 1));
            expect_wr(i, DW'(i + 1));
        end
        chk("fv_lag", frame_valid, 0);
        @(negedge clk);
        chk("fv_first", frame_valid, 1);
        chk("fb_first", frame_bank, 0);

        for (int i = 4; i < 8; i++) begin
            send(DW'(i + 1));
            expect_wr(i, DW'(i + 1));
        end
        @(negedge clk);
        chk("fv_both", frame_valid, 1);
        send(16'h0009);
        chk("drop_we", ram_we, 0);
        chk("drop_ovr", overrun, 1);

        @(negedge clk);
        sort_done = 1'b1;
        @(negedge clk);
        sort_done = 1'b0;
        @(negedge clk);
        chk("rel_fb", frame_bank, 1);
        chk("rel_fv", frame_valid, 1);
        send(16'h000A);
        expect_wr(0, 16'h000A);
        send(16'h000B);
        expect_wr(1, 16'h000B);

        en_rec_in = 1'b0;
        for (int i = 0; i < 3; i++) begin
            send(DW'(16'h00C0 + i));
            chk("gap_we", ram_we, 0);
        end
        en_rec_in = 1'b1;
        send(16'h000F);
        expect_wr(2, 16'h000F);

        do_reset();
        send(16'h0010);
        expect_wr(0, 16'h0010);
        chk("post_rst_ovr", overrun, 0);
        chk("post_rst_fv", frame_valid, 0);

        for (int i = 1; i < 8; i++) begin
            send(DW'(16'h0010 + i));
            expect_wr(i, DW'(16'h0010 + i));
        end
        @(negedge clk);
        chk("full2_fv", frame_valid, 1);
        chk("full2_fb", frame_bank, 0);
        @(negedge clk);
        fs = 1'b1;
        sort_done = 1'b1;
        data_in = 16'hBEEF;
        @(negedge clk);
        fs = 1'b0;
        sort_done = 1'b0;
        expect_wr(0, 16'hBEEF);
        chk("same_cyc_ovr", overrun, 0);

        for (int k = 0; k < 4000; k++) begin
            @(negedge clk);
            fs = 1'($urandom_range(0, 1));
            en_rec_in = ($urandom_range(0, 9) != 0);
            sort_done = ($urandom_range(0, 15) == 0);
            data_in = DW'($urandom);
            if ($urandom_range(0, 799) == 0) do_reset();
        end

        @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
